async_fifo: RTL and testbench

Single-clock FIFO buffer with binary and Gray-coded read/write pointers. It decouples a producer and a consumer that share one clock and exposes its internal pointers for debug and verification. Depth is 2^ADDR_WIDTH words of DATA_WIDTH bits. Flags come straight from the pointer registers.

---
 rtl/async_fifo.sv | 69 ++++++
 tb/tb_async_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// Purpose : single-clock FIFO, 2^ADDR_WIDTH x DATA_WIDTH, with binary and Gray
//           pointers exposed for debug. empty/full are decoded from the Gray pointers.
// Latency : a write at edge N clears empty after edge N. A read accepted at edge N
//           drives Dout after edge N. Reads do not fall through from a write in the same cycle.
// Backpressure: a write while full, or a read while empty, is silently dropped.
//           When both requests arrive at a boundary, only the legal side is accepted.
// Ports   : clk, rst (async, active-high); en_wr/Din write side; en_rd/Dout read side;
//           empty/full flags; head_*/tail_* are the write/read pointers in binary and Gray.
module async_fifo #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_wr,
  input  logic                  en_rd,
  input  logic [DATA_WIDTH-1:0] Din,
  output logic [DATA_WIDTH-1:0] Dout,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   head_bin,
  output logic [ADDR_WIDTH:0]   tail_bin,
  output logic [ADDR_WIDTH:0]   head_gray,
  output logic [ADDR_WIDTH:0]   tail_gray
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Full in Gray code means the top two bits are inverted and the rest match,
  // i.e. the XOR of the two pointers equals 2'b11 followed by zeros.
  localparam logic [ADDR_WIDTH:0] FULL_XOR = (ADDR_WIDTH+1)'(3) << (ADDR_WIDTH-1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_acc;
  logic                  rd_acc;

  assign head_gray = head_bin ^ (head_bin >> 1);
  assign tail_gray = tail_bin ^ (tail_bin >> 1);

  assign empty = (head_gray == tail_gray);
  assign full  = ((head_gray ^ tail_gray) == FULL_XOR);

  assign wr_acc = en_wr & ~full;
  assign rd_acc = en_rd & ~empty;

  // Storage is intentionally not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[head_bin[ADDR_WIDTH-1:0]] <= Din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_bin <= '0;
      tail_bin <= '0;
      Dout     <= '0;
    end else begin
      if (wr_acc) begin
        head_bin <= head_bin + 1'b1;
      end
      if (rd_acc) begin
        tail_bin <= tail_bin + 1'b1;
        Dout     <= mem[tail_bin[ADDR_WIDTH-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
module tb_async_fifo;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 1 << (AW + 1);

  logic          clk;
  logic          rst;
  logic          en_wr;
  logic          en_rd;
  logic [DW-1:0] Din;
  logic [DW-1:0] Dout;
  logic          empty;
  logic          full;
  logic [AW:0]   head_bin;
  logic [AW:0]   tail_bin;
  logic [AW:0]   head_gray;
  logic [AW:0]   tail_gray;

  async_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en_wr(en_wr), .en_rd(en_rd), .Din(Din), .Dout(Dout),
    .empty(empty), .full(full), .head_bin(head_bin), .tail_bin(tail_bin),
    .head_gray(head_gray), .tail_gray(tail_gray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks   = 0;
  int unsigned n_failures = 0;

  // Reference model: a plain queue of words plus total accept counters.
  logic [DW-1:0] q[$];
  int            wr_total;
  int            rd_total;
  logic [DW-1:0] exp_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_gray(input int v);
    logic [31:0] b;
    b = 32'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic check_state();
    int hb;
    int tb;
    hb = wr_total % PMOD;
    tb = rd_total % PMOD;
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("dout", 32'(Dout), 32'(exp_dout));
    check("head_bin", 32'(head_bin), 32'(hb));
    check("tail_bin", 32'(tail_bin), 32'(tb));
    check("head_gray", 32'(head_gray), to_gray(hb));
    check("tail_gray", 32'(tail_gray), to_gray(tb));
  endtask

  task automatic model_reset();
    q.delete();
    wr_total = 0;
    rd_total = 0;
    exp_dout = '0;
  endtask

  // One clock cycle of requests; inputs change 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit          wacc;
    bit          racc;
    logic [AW:0] ph;
    logic [AW:0] pt;
    wacc  = w && (q.size() < DEPTH);
    racc  = r && (q.size() > 0);
    ph    = head_gray;
    pt    = tail_gray;
    en_wr = w;
    en_rd = r;
    Din   = d;
    @(posedge clk);
    #1;
    en_wr = 1'b0;
    en_rd = 1'b0;
    if (racc) begin
      exp_dout = q.pop_front();
      rd_total++;
    end
    if (wacc) begin
      q.push_back(d);
      wr_total++;
    end
    check_state();
    if (wacc) check("head_gray_1bit", 32'($countones(head_gray ^ ph)), 32'd1);
    if (racc) check("tail_gray_1bit", 32'($countones(tail_gray ^ pt)), 32'd1);
  endtask

  initial begin
    en_wr = 1'b0;
    en_rd = 1'b0;
    Din   = '0;
    rst   = 1'b0;
    model_reset();

    // Reset asserted before any clock edge: outputs must settle immediately.
    #1 rst = 1'b1;
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dout", 32'(Dout), 32'd0);
    check("rst_head_bin", 32'(head_bin), 32'd0);
    check("rst_tail_bin", 32'(tail_bin), 32'd0);
    check("rst_head_gray", 32'(head_gray), 32'd0);
    check("rst_tail_gray", 32'(tail_gray), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single word round trip.
    step(1'b1, 1'b0, 8'hA5);
    check("single_not_empty", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    check("single_dout", 32'(Dout), 32'hA5);
    check("single_head_gray", 32'(head_gray), 32'd1);
    check("single_tail_gray", 32'(tail_gray), 32'd1);

    // Read while empty is dropped.
    step(1'b0, 1'b1, 8'h00);

    // Simultaneous at empty: only the write lands, Dout unchanged.
    step(1'b1, 1'b1, 8'h3C);
    check("sim_empty_dout", 32'(Dout), 32'hA5);
    step(1'b0, 1'b1, 8'h00);
    check("sim_empty_then_read", 32'(Dout), 32'h3C);

    // Fill from a fresh reset so the pointer values match the plan exactly.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_head_bin", 32'(head_bin), 32'd8);
    check("fill_head_gray", 32'(head_gray), 32'b1100);
    step(1'b1, 1'b0, 8'hEE);
    check("overflow_head_bin", 32'(head_bin), 32'd8);

    // Simultaneous at full: only the read is accepted.
    step(1'b1, 1'b1, 8'hDD);
    check("sim_full_read", 32'(Dout), 32'h01);
    check("sim_full_drop", 32'(full), 32'd0);

    // Mid-level simultaneous: occupancy constant.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'h40 + i));

    // Drain: remaining words in order.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
    check("drain_empty", 32'(empty), 32'd1);

    // Random soak at the nominal rates, then a write-heavy phase to hit full often.
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0, 8'($urandom));
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom));

    // Mid-operation reset discards data without a clock edge.
    step(1'b1, 1'b0, 8'h77);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_full", 32'(full), 32'd0);
    check("midrst_dout", 32'(Dout), 32'd0);
    check("midrst_head_bin", 32'(head_bin), 32'd0);
    check("midrst_tail_gray", 32'(tail_gray), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_dout", 32'(Dout), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
